// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer. `WORD is the global datapath width macro.
`ifndef WORD
`define WORD 32
`endif

package store_buffer_pkg;

    localparam int unsigned STORE_BUF_DEPTH = 4;

    typedef struct packed {
        logic [`WORD-1:0] addr;
        logic [`WORD-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core- and memory-side signal bundle of the store buffer.
// The forwarding lookup signals exist only when STORE_BUF_FWD_EN is defined.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic             memWrite;
    logic [`WORD-1:0] ALUResult;
    logic [`WORD-1:0] writeData;
    logic             full;
    logic             overflow;
    logic             memValid;
    logic [`WORD-1:0] memAddr;
    logic [`WORD-1:0] memData;
    logic             memReady;
`ifdef STORE_BUF_FWD_EN
    logic [`WORD-1:0] loadAddr;
    logic             fwdHit;
    logic [`WORD-1:0] fwdData;

    modport master (
        output memWrite, ALUResult, writeData, memReady, loadAddr,
        input  full, overflow, memValid, memAddr, memData, fwdHit, fwdData
    );
    modport slave (
        input  memWrite, ALUResult, writeData, memReady, loadAddr,
        output full, overflow, memValid, memAddr, memData, fwdHit, fwdData
    );
`else
    modport master (
        output memWrite, ALUResult, writeData, memReady,
        input  full, overflow, memValid, memAddr, memData
    );
    modport slave (
        input  memWrite, ALUResult, writeData, memReady,
        output full, overflow, memValid, memAddr, memData
    );
`endif

endinterface

// File: rtl/store_buffer_fifo.sv
// Generic in-order FIFO of sb_entry_t with wrapping pointers, occupancy count and a per-slot
// valid vector. The caller guarantees push only when a slot is free (or a pop frees one).
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned Depth = STORE_BUF_DEPTH,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  sb_entry_t       wr_entry,
    output logic            full,
    output logic            empty,
    output logic [PtrW-1:0] head,
    output logic [Depth-1:0] valid,
    output sb_entry_t       entries [Depth]
);

    sb_entry_t       mem_q [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; only slots below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    // A slot is valid when its distance from head (mod Depth) is below the count.
    for (genvar i = 0; i < Depth; i++) begin : g_valid
        assign valid[i] = CntW'(PtrW'(i) - head_q) < count_q;
    end

    assign entries = mem_q;
    assign head    = head_q;
    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core's store outputs and data memory, with sticky overflow.
// Define STORE_BUF_FWD_EN to add the youngest-match store-to-load forwarding port.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STORE_BUF_DEPTH
) (
    input logic         clk,
    input logic         rst_n,
    store_buffer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PtrW-1:0]  head;
    logic [DEPTH-1:0] valid;
    sb_entry_t        entries [DEPTH];
    sb_entry_t        wr_entry;
    logic             overflow_q, overflow_d;

    // memValid depends on count only, so memReady never loops back into it.
    assign pop      = !empty && bus.memReady;
    assign push     = bus.memWrite && (!full || pop);
    assign wr_entry = '{addr: bus.ALUResult, data: bus.writeData};

    store_buffer_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .valid    (valid),
        .entries  (entries)
    );

    assign overflow_d = overflow_q || (bus.memWrite && full && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.full     = full;
    assign bus.overflow = overflow_q;
    assign bus.memValid = !empty;
    assign bus.memAddr  = entries[head].addr;
    assign bus.memData  = entries[head].data;

`ifdef STORE_BUF_FWD_EN
    logic             fwd_hit;
    logic [`WORD-1:0] fwd_data;
    logic [PtrW-1:0]  idx;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PtrW'(k);
            if (valid[idx] && (entries[idx].addr == bus.loadAddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end

    assign bus.fwdHit  = fwd_hit;
    assign bus.fwdData = fwd_data;
`else
    logic unused_valid;
    assign unused_valid = ^valid;
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer sitting directly downstream of the CPU core's memory-write outputs. Captures each store (address = ALU result, data = write data) in the cycle the core asserts its memory-write strobe, queues it in order, and drains it to data memory over a valid/ready handshake. The single-cycle core never waits on memory for stores. An optional forwarding port lets a load see the youngest buffered store to the same address.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- memWrite  in  1  store request from core, one per cycle max.
- ALUResult  in  `WORD  store address.
- writeData  in  `WORD  store data.
- full  out  1  no free entry this cycle (count == DEPTH).
- overflow  out  1  sticky: a store was dropped.
- memValid  out  1  head entry presented to memory.
- memAddr  out  `WORD  head address.
- memData  out  `WORD  head data.
- memReady  in  1  memory accepts head this cycle.
- loadAddr  in  `WORD  forwarding lookup address (only with STORE_BUF_FWD_EN).
- fwdHit  out  1  a buffered store matches loadAddr (only with STORE_BUF_FWD_EN).
- fwdData  out  `WORD  data of youngest matching entry (only with STORE_BUF_FWD_EN).

## Operation
- Storage: DEPTH entries of {addr, data}, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, count of $clog2(DEPTH+1) bits.
- pop = memValid && memReady; advances head and decrements count.
- push = memWrite && (count < DEPTH || pop); writes {ALUResult, writeData} at tail and advances tail.
- Simultaneous push and pop: count unchanged; push is legal when full because pop frees a slot in the same edge.
- memWrite when full and no pop: store dropped, state unchanged, overflow set; overflow clears only on reset.
- memValid = (count != 0); memAddr/memData driven from head entry; held stable while memValid && !memReady.
- Order strictly FIFO; no merging or coalescing of stores.
- Stores of the same address are kept as separate entries.

## Timing
- Reset (async, rst_n low): count=0, head=tail=0, overflow=0. memValid=0 and full=0 immediately, not at the next edge. Entry contents are don't-care. Buffered stores are lost, including when reset arrives mid-drain.
- Latency: a store pushed at edge N appears on memValid/memAddr/memData after edge N (earliest pop at edge N+1). There is no same-cycle bypass from input to memory side.
- Throughput: one push and one pop per cycle sustained.
- full and memValid are combinational from count only; memReady never affects memValid, so there is no combinational loop.
- overflow rises after the edge on which the drop occurs.

## Configuration
- STORE_BUF_FWD_EN defined:
  - loadAddr, fwdHit and fwdData ports exist.
  - Combinational full-width compare of loadAddr against every valid entry.
  - fwdHit=1 if any entry matches; fwdData comes from the match closest to the tail (youngest).
  - An entry popping this cycle still counts as valid for the compare.
  - fwdHit=0 and fwdData=0 when there is no match or the buffer is empty.
- STORE_BUF_FWD_EN undefined: the three ports and the compare logic are absent. The block is a pure drain FIFO.

## Structure
- Shared package:
  - typedef sb_entry_t {logic [`WORD-1:0] addr; logic [`WORD-1:0] data;}.
  - localparam STORE_BUF_DEPTH default (4).
- `WORD stays the existing global macro.
- Sub-module: store_buffer_fifo. Generic sb_entry_t FIFO holding the pointers, count, push/pop, full/empty and per-entry valid vector. The top adds the overflow flag and the forwarding compare, which reads the FIFO storage and valid vector.

## Test plan
- Reset then a single store: memWrite=1, addr 0x100, data 0xDEAD for one cycle, memReady=1 → memValid high the next cycle with 0x100/0xDEAD, popped one cycle later, then memValid=0.
- Backpressure: push 4 stores (0x0,0x4,0x8,0xC) with memReady=0 → full=1, memAddr held at 0x0. Release memReady → drain in order 0x0,0x4,0x8,0xC on consecutive cycles.
- Full plus simultaneous push/pop: buffer full and memReady=1 while pushing 0x10 → head pops, 0x10 enqueued, count stays 4, overflow stays 0.
- Overflow: buffer full, memReady=0, push 0x20 → entry dropped, overflow=1 and stays 1; the drained sequence does not contain 0x20.
- Forwarding (STORE_BUF_FWD_EN): buffer 0x40→0x1111 then 0x40→0x2222, loadAddr=0x40 → fwdHit=1, fwdData=0x2222. loadAddr=0x44 → fwdHit=0.
- Reset mid-drain: 3 entries queued, rst_n pulsed low asynchronously between edges → memValid=0 and full=0 immediately, and no further memory transfers occur.
